enigma_key_sequencer: RTL

- Per-keystroke controller for the Enigma datapath (plugboard -> rotors/reflector -> plugboard).
- On each new one-hot keystroke it latches the key and advances the three rotor positions with true Enigma stepping, including the middle-rotor double-step.
- It then holds the latched key steady while the combinational datapath settles, and captures the enciphered one-hot letter.
- It presents the captured letter to the GUI through a valid/ready handshake. Manual single-rotor stepping from pushbuttons is accepted only while idle.

---
 rtl/enigma_key_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/enigma_key_sequencer.sv
// Per-keystroke controller for the Enigma datapath: latches one key, steps the rotors,
// waits for the combinational datapath to settle, then hands the enciphered letter out.
`timescale 1ns/1ps
module enigma_key_sequencer #(
  parameter int SETTLE_CYCLES = 4,   // 1..15
  parameter int NOTCH1        = 16,
  parameter int NOTCH2        = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [25:0] key_in,
  input  logic        step1,
  input  logic        step2,
  input  logic        step3,
  output logic [25:0] key_hold,
  input  logic [25:0] enc_in,
  output logic [4:0]  state1,
  output logic [4:0]  state2,
  output logic [4:0]  state3,
  output logic [25:0] enc_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_SETTLE,
    S_PRESENT,
    S_RELEASE
  } state_t;

  localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] LP_NOTCH1      = 5'(NOTCH1);
  localparam logic [4:0] LP_NOTCH2      = 5'(NOTCH2);

  state_t      r_state;
  state_t      w_state_next;
  logic [25:0] r_key_hold;
  logic [25:0] r_enc_out;
  logic [4:0]  r_pos1;
  logic [4:0]  r_pos2;
  logic [4:0]  r_pos3;
  logic [3:0]  r_settle_cnt;
  logic [2:0]  r_step_prev;
  logic        r_out_valid;
  logic        r_fault;

  logic [2:0]  w_step_rise;
  logic        w_key_onehot;
  logic        w_enc_onehot;
  logic        w_mid_step;
  logic        w_slow_step;
  logic        w_settle_done;

  function automatic logic is_onehot(input logic [25:0] v);
    return (v != 26'd0) && ((v & (v - 26'd1)) == 26'd0);
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  assign w_step_rise   = {step3, step2, step1} & ~r_step_prev;
  assign w_key_onehot  = is_onehot(key_in);
  assign w_enc_onehot  = is_onehot(enc_in);
  // Middle-rotor notch also drags the middle rotor itself: the Enigma double-step.
  assign w_slow_step   = (r_pos2 == LP_NOTCH2);
  assign w_mid_step    = (r_pos1 == LP_NOTCH1) || w_slow_step;
  assign w_settle_done = (r_settle_cnt == 4'd0);

  // Reset lands in RELEASE so a key held through reset is never enciphered.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_RELEASE;
    else       r_state <= w_state_next;
  end

  // NOTE: the default assignment before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_key_onehot)     w_state_next = S_STEP;
      S_STEP:                          w_state_next = S_SETTLE;
      S_SETTLE:  if (w_settle_done)    w_state_next = S_PRESENT;
      S_PRESENT: if (out_ready)        w_state_next = S_RELEASE;
      S_RELEASE: if (key_in == 26'd0)  w_state_next = S_IDLE;
      default:                         w_state_next = S_RELEASE;
    endcase
  end

  // NOTE: non-blocking assignments make all three rotors see the pre-step positions in the same edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_key_hold   <= 26'd0;
      r_enc_out    <= 26'd0;
      r_pos1       <= 5'd0;
      r_pos2       <= 5'd0;
      r_pos3       <= 5'd0;
      r_settle_cnt <= 4'd0;
      r_step_prev  <= 3'b111;
      r_out_valid  <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_step_prev <= {step3, step2, step1};
      case (r_state)
        S_IDLE: begin
          if (w_key_onehot) begin
            r_key_hold <= key_in;
          end else begin
            if (w_step_rise[0]) r_pos1 <= inc26(r_pos1);
            if (w_step_rise[1]) r_pos2 <= inc26(r_pos2);
            if (w_step_rise[2]) r_pos3 <= inc26(r_pos3);
          end
        end
        S_STEP: begin
          r_pos1 <= inc26(r_pos1);
          if (w_mid_step)  r_pos2 <= inc26(r_pos2);
          if (w_slow_step) r_pos3 <= inc26(r_pos3);
          r_settle_cnt <= LP_SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (w_settle_done) begin
            r_enc_out   <= enc_in;
            r_out_valid <= 1'b1;
            if (!w_enc_onehot) r_fault <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_key_hold  <= 26'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_hold  = r_key_hold;
  assign enc_out   = r_enc_out;
  assign state1    = r_pos1;
  assign state2    = r_pos2;
  assign state3    = r_pos3;
  assign out_valid = r_out_valid;
  assign fault     = r_fault;

endmodule
